// File: rtl/code_loader_pkg.sv
// -----------------------------------------------------------------------------
// code_loader_pkg
// Shared constants and types for the serial code loader.
//   LOADER_SYNC       : frame sync byte that opens a load
//   LOADER_MAX_WORDS  : code memory depth in 16-bit words
//   ld_state_t        : frame FSM states (code_loader)
//   rx_state_t        : UART byte receiver states (uart_rx_byte)
//   len_ok()          : word-count range check used on LEN_LO
// -----------------------------------------------------------------------------
package code_loader_pkg;

  localparam logic [7:0] LOADER_SYNC      = 8'hA5;
  localparam int         LOADER_MAX_WORDS = 512;
  localparam logic [9:0] LOADER_MAX_LEN   = 10'(LOADER_MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_ERR     = 3'd6
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A frame must carry at least one word and no more than memory holds.
  function automatic logic len_ok(input logic [9:0] n);
    return (n != 10'd0) && (n <= LOADER_MAX_LEN);
  endfunction

endpackage

// File: rtl/code_loader_rx.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver, LSB first.
//   clk, rst        : system clock, synchronous active-high reset
//   rx              : asynchronous serial line, idle high
//   data[7:0]       : received byte, valid while byte_valid is high
//   byte_valid      : one-cycle pulse at the stop-bit sample
//   frame_err       : stop bit was sampled low (qualified by byte_valid)
// The line is double-flopped before use. A falling edge on the synchronized
// line opens a start-bit check; the start bit is re-sampled half a bit later
// and a high level there is treated as a glitch. Data and stop bits are then
// sampled one full bit period apart.
// -----------------------------------------------------------------------------
module uart_rx_byte
  import code_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_rx_d;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;

  assign data       = r_data;
  assign byte_valid = r_valid;
  assign frame_err  = r_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle level so reset release is not an edge.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_rx_d && !r_sync2) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_data  <= r_shift;
            r_ferr  <= ~r_sync2;
            r_valid <= 1'b1;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/code_loader.sv
// -----------------------------------------------------------------------------
// code_loader
// Serial program loader: receives a framed byte stream over UART, writes
// 16-bit words into code memory and enables the processor after a frame
// with a good checksum.
//   Frame: A5, LEN_HI, LEN_LO, N x {hi, lo}, CHK ; N = {LEN_HI[1:0], LEN_LO}
//          CHK = XOR of LEN_HI, LEN_LO and every data byte.
//   clk, rst      : system clock, synchronous active-high reset
//   rx            : UART line (8N1, idle high)
//   code_w_en     : one-cycle code-memory write strobe
//   code_addr_in  : word address of the write
//   code_in       : instruction word of the write
//   run           : processor enable, high after a good load
//   busy          : high from sync acceptance until the frame ends
//   err           : sticky load error, cleared by the next accepted sync
// -----------------------------------------------------------------------------
module code_loader
  import code_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        code_w_en,
  output logic [8:0]  code_addr_in,
  output logic [15:0] code_in,
  output logic        run,
  output logic        busy,
  output logic        err
);

  logic [7:0] w_data;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic       w_in_frame;
  logic       w_fail;
  logic [9:0] w_len;

  ld_state_t  r_state;
  logic [9:0] r_len;
  logic [1:0] r_len_hi;
  logic [9:0] r_idx;
  logic [7:0] r_hi;
  logic [7:0] r_chk;
  logic       r_w_en;
  logic [8:0] r_addr;
  logic [15:0] r_code;
  logic       r_run;
  logic       r_busy;
  logic       r_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (w_data),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  assign code_w_en    = r_w_en;
  assign code_addr_in = r_addr;
  assign code_in      = r_code;
  assign run          = r_run;
  assign busy         = r_busy;
  assign err          = r_err;

  assign w_in_frame = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_len      = {r_len_hi, w_data};

  // Every way a byte inside a frame can abort the load. The checksum compare
  // uses the XOR accumulated before CHK itself is folded in.
  always_comb begin
    w_fail = 1'b0;
    if (w_byte_valid && w_in_frame) begin
      if (w_frame_err) begin
        w_fail = 1'b1;
      end else begin
        case (r_state)
          S_LEN_HI: w_fail = (w_data[7:2] != 6'd0);
          S_LEN_LO: w_fail = ~len_ok(w_len);
          S_CHECK:  w_fail = (r_chk != w_data);
          default:  w_fail = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_len_hi <= '0;
      r_idx    <= '0;
      r_hi     <= '0;
      r_chk    <= '0;
      r_w_en   <= 1'b0;
      r_addr   <= '0;
      r_code   <= '0;
      r_run    <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      if (w_byte_valid) begin
        if (!w_in_frame) begin
          // IDLE and ERR: only a clean sync byte is acted on.
          if (!w_frame_err && (w_data == LOADER_SYNC)) begin
            r_state <= S_LEN_HI;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_chk   <= '0;
          end
        end else if (w_fail) begin
          // Words already written stay in memory.
          r_state <= S_ERR;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_run   <= 1'b0;
        end else begin
          r_chk <= r_chk ^ w_data;
          case (r_state)
            S_LEN_HI: begin
              r_len_hi <= w_data[1:0];
              r_state  <= S_LEN_LO;
            end
            S_LEN_LO: begin
              r_len   <= w_len;
              r_state <= S_DATA_HI;
            end
            S_DATA_HI: begin
              r_hi    <= w_data;
              r_state <= S_DATA_LO;
            end
            S_DATA_LO: begin
              r_w_en  <= 1'b1;
              r_addr  <= r_idx[8:0];
              r_code  <= {r_hi, w_data};
              r_idx   <= r_idx + 10'd1;
              r_state <= (r_idx + 10'd1 == r_len) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
              r_state <= S_IDLE;
              r_run   <= 1'b1;
              r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

  localparam int CPB = 4;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        code_w_en;
  logic [8:0]  code_addr_in;
  logic [15:0] code_in;
  logic        run;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [24:0] strobes[$];

  code_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .code_w_en    (code_w_en),
    .code_addr_in (code_addr_in),
    .code_in      (code_in),
    .run          (run),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && code_w_en) strobes.push_back({code_addr_in, code_in});
  end

  typedef struct packed {
    logic [3:0]  nb;
    logic [79:0] b;
    logic        run;
    logic        err;
    logic [9:0]  nstr;
    logic [24:0] s0;
    logic [24:0] s1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] strobe_at(input int i);
    if (i < strobes.size()) return strobes[i];
    return 25'h1FFFFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] bt;
    int         nbad;

    vecs[0] = '{nb: 4'd10, b: 80'h00FF_A500_0212_34AB_CD42, run: 1'b1, err: 1'b0,
                nstr: 10'd2, s0: {9'h000, 16'h1234}, s1: {9'h001, 16'hABCD}};
    vecs[1] = '{nb: 4'd8,  b: 80'hA500_0212_34AB_CD43_0000, run: 1'b0, err: 1'b1,
                nstr: 10'd2, s0: {9'h000, 16'h1234}, s1: {9'h001, 16'hABCD}};
    vecs[2] = '{nb: 4'd8,  b: 80'hA500_0212_34AB_CD42_0000, run: 1'b1, err: 1'b0,
                nstr: 10'd2, s0: {9'h000, 16'h1234}, s1: {9'h001, 16'hABCD}};
    vecs[3] = '{nb: 4'd3,  b: 80'hA500_0000_0000_0000_0000, run: 1'b0, err: 1'b1,
                nstr: 10'd0, s0: '0, s1: '0};
    vecs[4] = '{nb: 4'd3,  b: 80'hA502_0100_0000_0000_0000, run: 1'b0, err: 1'b1,
                nstr: 10'd0, s0: '0, s1: '0};
    vecs[5] = '{nb: 4'd2,  b: 80'hA504_0000_0000_0000_0000, run: 1'b0, err: 1'b1,
                nstr: 10'd0, s0: '0, s1: '0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {code_w_en, code_addr_in, code_in, run, busy, err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      strobes.delete();
      for (int i = 0; i < int'(vecs[v].nb); i++) begin
        bt = vecs[v].b[79 - 8*i -: 8];
        send_byte(bt, 1'b1);
        if (bt == 8'hA5) begin
          check($sformatf("v%0d_after_sync_run_busy_err", v), {run, busy, err}, 3'b010);
        end
      end
      check($sformatf("v%0d_run", v),  run,  vecs[v].run);
      check($sformatf("v%0d_err", v),  err,  vecs[v].err);
      check($sformatf("v%0d_busy", v), busy, 1'b0);
      check($sformatf("v%0d_nstrobes", v), strobes.size(), vecs[v].nstr);
      if (vecs[v].nstr == 10'd2) begin
        check($sformatf("v%0d_strobe0", v), strobe_at(0), vecs[v].s0);
        check($sformatf("v%0d_strobe1", v), strobe_at(1), vecs[v].s1);
      end
    end

    // Full-size frame: 512 words, word k = k
    strobes.delete();
    x = 8'h02 ^ 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 512; k++) begin
      logic [15:0] w;
      w = 16'(k);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
      x = x ^ w[15:8] ^ w[7:0];
    end
    send_byte(x, 1'b1);
    check("max_nstrobes", strobes.size(), 512);
    nbad = 0;
    for (int k = 0; k < 512; k++) begin
      if (strobe_at(k) !== {9'(k), 16'(k)}) nbad++;
    end
    check("max_strobe_contents_bad", nbad, 0);
    check("max_last_strobe", strobe_at(511), {9'h1FF, 16'h01FF});
    check("max_run_err_busy", {run, err, busy}, 3'b100);

    // Framing error on the 4th byte of a good frame
    strobes.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    check("ferr_err_busy_run", {err, busy, run}, 3'b100);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h42, 1'b1);
    check("ferr_nstrobes", strobes.size(), 0);
    check("ferr_final_err_run", {err, run}, 2'b10);

    // One-cycle low glitch between bytes of a frame must not become a byte
    strobes.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy_still", busy, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h27, 1'b1);
    check("glitch_nstrobes", strobes.size(), 1);
    check("glitch_strobe0", strobe_at(0), {9'h000, 16'h1234});
    check("glitch_run_err", {run, err}, 2'b10);

    // Reset mid-frame
    strobes.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    check("midrst_busy_before", busy, 1'b1);
    pulse_reset();
    check("midrst_outputs", {code_w_en, code_addr_in, code_in, run, busy, err}, 32'h0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] fr;
      fr = 64'hA500_0212_34AB_CD42;
      send_byte(fr[63 - 8*i -: 8], 1'b1);
    end
    check("midrst_nstrobes", strobes.size(), 2);
    check("midrst_strobe1", strobe_at(1), {9'h001, 16'hABCD});
    check("midrst_run_err", {run, err}, 2'b10);

    // Reload while running
    strobes.delete();
    check("reload_run_before", run, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("reload_after_sync", {run, busy, err}, 3'b010);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("reload_run_low_before_chk", run, 1'b0);
    send_byte(8'h32, 1'b1);
    check("reload_strobe0", strobe_at(0), {9'h000, 16'h5566});
    check("reload_run_busy_err", {run, busy, err}, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
